// File: rtl/s_box_engine.sv
// -----------------------------------------------------------------------------
// s_box_engine
// Sequential S-box substitution engine. A WORD_W-bit word is split into
// N = WORD_W/DIGIT_W digits, and one digit per clock is substituted through
// a table supplied on Key. Mode selects forward or inverse substitution.
// A start/busy/done handshake frames each word. KeyErr flags a latched table
// that is not a permutation.
//
// Ports
//   Clk     in   1       rising-edge clock
//   Rst     in   1       asynchronous active-high reset
//   Start   in   1       request, accepted in IDLE or DONE
//   Mode    in   1       0 = forward, 1 = inverse (latched at accept)
//   In      in   WORD_W  data word (latched at accept)
//   Key     in   KEY_W   table, entry k = Key[k*DIGIT_W +: DIGIT_W]
//   Out     out  WORD_W  result word, held until the next completion
//   Busy    out  1       high while running
//   Done    out  1       one-cycle completion pulse
//   KeyErr  out  1       latched key has duplicate entries
// -----------------------------------------------------------------------------
module s_box_engine #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned DIGIT_W = 2
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    input  logic                                 Start,
    input  logic                                 Mode,
    input  logic [WORD_W-1:0]                    In,
    input  logic [(1 << DIGIT_W)*DIGIT_W-1:0]    Key,
    output logic [WORD_W-1:0]                    Out,
    output logic                                 Busy,
    output logic                                 Done,
    output logic                                 KeyErr
);

    localparam int unsigned N     = WORD_W / DIGIT_W;
    localparam int unsigned T     = 1 << DIGIT_W;
    localparam int unsigned KEY_W = T * DIGIT_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // Reject parameter combinations that do not tile the word into digits.
    if (DIGIT_W < 1 || DIGIT_W > 4 || WORD_W == 0 || (WORD_W % DIGIT_W) != 0) begin : g_param_err
        $error("s_box_engine: WORD_W must be a positive multiple of DIGIT_W, DIGIT_W in 1..4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_W-1:0]    work;
    logic [WORD_W-1:0]    res;
    logic [KEY_W-1:0]     key_q;
    logic                 mode_q;
    logic                 key_err_q;

    logic [DIGIT_W-1:0]   digit_c;
    logic [DIGIT_W-1:0]   fwd_c;
    logic [DIGIT_W-1:0]   inv_c;
    logic [DIGIT_W-1:0]   sub_c;
    logic [WORD_W-1:0]    res_next_c;
    logic                 last_c;
    logic                 key_err_c;

    // Select the current digit, substitute it, and merge it into the result.
    always_comb begin
        digit_c    = '0;
        fwd_c      = '0;
        inv_c      = '0;
        sub_c      = '0;
        res_next_c = res;
        last_c     = (cnt == CNT_W'(N - 1));

        for (int unsigned j = 0; j < N; j++) begin
            if (cnt == CNT_W'(j)) begin
                digit_c = work[j*DIGIT_W +: DIGIT_W];
            end
        end

        // Descending scan so the lowest matching index wins for the inverse;
        // an unmatched value leaves the inverse at zero.
        for (int k = int'(T) - 1; k >= 0; k--) begin
            if (DIGIT_W'(k) == digit_c) begin
                fwd_c = key_q[k*DIGIT_W +: DIGIT_W];
            end
            if (key_q[k*DIGIT_W +: DIGIT_W] == digit_c) begin
                inv_c = DIGIT_W'(k);
            end
        end

        sub_c = mode_q ? inv_c : fwd_c;

        for (int unsigned j = 0; j < N; j++) begin
            if (cnt == CNT_W'(j)) begin
                res_next_c[j*DIGIT_W +: DIGIT_W] = sub_c;
            end
        end
    end

    // Permutation check on the incoming key; captured together with the key.
    always_comb begin
        key_err_c = 1'b0;
        for (int unsigned a = 0; a < T; a++) begin
            for (int unsigned b = a + 1; b < T; b++) begin
                if (Key[a*DIGIT_W +: DIGIT_W] == Key[b*DIGIT_W +: DIGIT_W]) begin
                    key_err_c = 1'b1;
                end
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            work      <= '0;
            res       <= '0;
            key_q     <= '0;
            mode_q    <= 1'b0;
            key_err_q <= 1'b0;
            Out       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            KeyErr    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        state     <= ST_RUN;
                        Busy      <= 1'b1;
                        work      <= In;
                        key_q     <= Key;
                        mode_q    <= Mode;
                        key_err_q <= key_err_c;
                        cnt       <= '0;
                        res       <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    res <= res_next_c;
                    if (last_c) begin
                        state  <= ST_DONE;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        Out    <= res_next_c;
                        KeyErr <= key_err_q;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s_box_engine.sv
// -----------------------------------------------------------------------------
// tb_s_box_engine
// Self-checking bench for s_box_engine: a default 8/2 instance and a 16/4
// instance, directed cases plus randomized words checked against a
// behavioural substitution model.
// -----------------------------------------------------------------------------
module tb_s_box_engine;

    logic        Clk = 1'b0;
    logic        Rst;

    logic        start8, mode8;
    logic [7:0]  in8, key8;
    logic [7:0]  out8;
    logic        busy8, done8, kerr8;

    logic        start16, mode16;
    logic [15:0] in16;
    logic [63:0] key16;
    logic [15:0] out16;
    logic        busy16, done16, kerr16;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    s_box_engine #(.WORD_W(8), .DIGIT_W(2)) u_dut8 (
        .Clk(Clk), .Rst(Rst), .Start(start8), .Mode(mode8), .In(in8), .Key(key8),
        .Out(out8), .Busy(busy8), .Done(done8), .KeyErr(kerr8)
    );

    s_box_engine #(.WORD_W(16), .DIGIT_W(4)) u_dut16 (
        .Clk(Clk), .Rst(Rst), .Start(start16), .Mode(mode16), .In(in16), .Key(key16),
        .Out(out16), .Busy(busy16), .Done(done16), .KeyErr(kerr16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: table lookup per digit, inverse by lowest matching index.
    task automatic ref_model(input logic [15:0] word, input logic [63:0] key, input logic mode,
                             input int ww, input int dw, output logic [15:0] res, output logic err);
        int t, mask, v, s;
        int e[16];
        t    = 1 << dw;
        mask = t - 1;
        for (int k = 0; k < t; k++) e[k] = int'(key >> (k * dw)) & mask;
        res = '0;
        for (int j = 0; j < ww / dw; j++) begin
            v = int'(word >> (j * dw)) & mask;
            if (!mode) s = e[v];
            else begin
                s = 0;
                for (int k = t - 1; k >= 0; k--) if (e[k] == v) s = k;
            end
            res = res | (16'(s) << (j * dw));
        end
        err = 1'b0;
        for (int a = 0; a < t; a++)
            for (int b = a + 1; b < t; b++)
                if (e[a] == e[b]) err = 1'b1;
    endtask

    function automatic logic [63:0] rand_perm_key(input int dw);
        int t, j, tmp;
        int p[16];
        logic [63:0] k;
        t = 1 << dw;
        for (int i = 0; i < t; i++) p[i] = i;
        for (int i = t - 1; i > 0; i--) begin
            j    = int'($urandom_range(i, 0));
            tmp  = p[i];
            p[i] = p[j];
            p[j] = tmp;
        end
        k = '0;
        for (int i = 0; i < t; i++) k = k | (64'(p[i]) << (i * dw));
        return k;
    endfunction

    task automatic drive(input bit w16, input logic s, input logic m,
                         input logic [15:0] d, input logic [63:0] k);
        if (w16) begin
            start16 = s; mode16 = m; in16 = d; key16 = k;
        end else begin
            start8 = s; mode8 = m; in8 = d[7:0]; key8 = k[7:0];
        end
    endtask

    function automatic logic [15:0] cur_out(input bit w16);
        return w16 ? out16 : {8'h00, out8};
    endfunction
    function automatic logic cur_busy(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction
    function automatic logic cur_done(input bit w16);
        return w16 ? done16 : done8;
    endfunction
    function automatic logic cur_kerr(input bit w16);
        return w16 ? kerr16 : kerr8;
    endfunction

    // One word: accept, optionally disturb inputs during the run, then check result.
    task automatic txn(input string tag, input bit w16, input logic m, input logic [15:0] d,
                       input logic [63:0] k, input bit scramble, input bit fixed,
                       input logic [15:0] xo, input logic xe);
        logic [15:0] eo;
        logic        ee;
        int          n, lat;
        bit          busy_ok;
        n = w16 ? 4 : 4;
        if (fixed) begin
            eo = xo; ee = xe;
        end else begin
            ref_model(d, k, m, w16 ? 16 : 8, w16 ? 4 : 2, eo, ee);
        end
        @(negedge Clk);
        drive(w16, 1'b1, m, d, k);
        @(negedge Clk);
        check({tag, "_busy_acc"}, 64'(cur_busy(w16)), 64'd1);
        lat     = 0;
        busy_ok = 1'b1;
        while (!cur_done(w16) && lat < 4 * n + 8) begin
            busy_ok = busy_ok & cur_busy(w16);
            if (scramble)
                drive(w16, 1'($urandom), ~m, 16'($urandom), {$urandom, $urandom});
            else
                drive(w16, 1'b0, m, d, k);
            @(negedge Clk);
            lat++;
        end
        drive(w16, 1'b0, m, d, k);
        check({tag, "_latency"}, 64'(lat), 64'(n));
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_out"}, 64'(cur_out(w16)), 64'(eo));
        check({tag, "_keyerr"}, 64'(cur_kerr(w16)), 64'(ee));
        check({tag, "_busy_done"}, 64'(cur_busy(w16)), 64'd0);
        @(negedge Clk);
        check({tag, "_done_pulse"}, 64'(cur_done(w16)), 64'd0);
        check({tag, "_out_held"}, 64'(cur_out(w16)), 64'(eo));
    endtask

    initial begin
        int          times[$];
        int          ndone;
        logic [63:0] k;
        logic        m;
        logic [15:0] d;

        Rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge Clk);
        check("rst_out8",  64'(out8),  64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_kerr8", 64'(kerr8), 64'd0);
        check("rst_out16", 64'(out16), 64'd0);
        Rst = 1'b0;

        // Directed cases on the default geometry.
        txn("fwd",   1'b0, 1'b0, 16'h001B, 64'h1E, 1'b0, 1'b1, 16'h00B4, 1'b0);
        txn("inv",   1'b0, 1'b1, 16'h00B4, 64'h1E, 1'b0, 1'b1, 16'h001B, 1'b0);
        txn("z_fwd", 1'b0, 1'b0, 16'h00FF, 64'h00, 1'b0, 1'b1, 16'h0000, 1'b1);
        txn("z_inv", 1'b0, 1'b1, 16'h0055, 64'h00, 1'b0, 1'b1, 16'h0000, 1'b1);
        txn("scram", 1'b0, 1'b0, 16'h001B, 64'h1E, 1'b1, 1'b1, 16'h00B4, 1'b0);

        // Start held high: one Done every N+1 cycles.
        @(negedge Clk);
        drive(1'b0, 1'b1, 1'b0, 16'h001B, 64'h1E);
        for (int i = 1; i <= 22; i++) begin
            @(negedge Clk);
            if (done8) begin
                times.push_back(i);
                check("b2b_out", 64'(out8), 64'hB4);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'h001B, 64'h1E);
        check("b2b_count", 64'(times.size()), 64'd4);
        for (int i = 1; i < times.size(); i++)
            check("b2b_gap", 64'(times[i] - times[i-1]), 64'd5);
        repeat (8) @(negedge Clk);

        // Reset mid-run discards the word.
        drive(1'b0, 1'b1, 1'b0, 16'h0027, 64'h1E);
        @(posedge Clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0027, 64'h1E);
        repeat (2) @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("rstrun_busy", 64'(busy8), 64'd0);
        check("rstrun_done", 64'(done8), 64'd0);
        check("rstrun_out",  64'(out8),  64'd0);
        @(negedge Clk);
        Rst   = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge Clk);
            if (done8) ndone++;
        end
        check("rstrun_nodone", 64'(ndone), 64'd0);
        txn("post_rst", 1'b0, 1'b0, 16'h001B, 64'h1E, 1'b0, 1'b1, 16'h00B4, 1'b0);

        // Wide geometry with the identity table and a corrupted table.
        txn("id_fwd",  1'b1, 1'b0, 16'hA5C3, 64'hFEDCBA9876543210, 1'b0, 1'b1, 16'hA5C3, 1'b0);
        txn("id_inv",  1'b1, 1'b1, 16'hA5C3, 64'hFEDCBA9876543210, 1'b0, 1'b1, 16'hA5C3, 1'b0);
        txn("bad_fwd", 1'b1, 1'b0, 16'hA5C3, 64'hFEDCBA9876543211, 1'b0, 1'b1, 16'hA5C3, 1'b1);
        txn("bad_inv", 1'b1, 1'b1, 16'hA5C1, 64'hFEDCBA9876543211, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Randomized words against the model.
        for (int i = 0; i < 24; i++) begin
            k = ($urandom_range(1, 0) == 1) ? rand_perm_key(2) : {32'h0, $urandom};
            m = 1'($urandom);
            d = 16'($urandom_range(255, 0));
            txn("rnd8", 1'b0, m, d, k, 1'($urandom), 1'b0, 16'h0000, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            k = ($urandom_range(1, 0) == 1) ? rand_perm_key(4) : {$urandom, $urandom};
            m = 1'($urandom);
            d = 16'($urandom);
            txn("rnd16", 1'b1, m, d, k, 1'b0, 1'b0, 16'h0000, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_box_engine.md
# s_box_engine

Parametrised sequential substitution (S-box) engine: splits a WORD_W-bit word into DIGIT_W-bit digits and substitutes one digit per clock through a programmable table. The table is supplied as a key port. The block supports both forward (encrypt) and inverse (decrypt) substitution, and uses a start/busy/done handshake. It is the generalised successor of the fixed 2-bit/8-bit S-transformation and sits in the cipher datapath between the key store and the permutation stage.

## Interface
- WORD_W, 8, data word width; must be a positive multiple of DIGIT_W (elaboration error otherwise)
- DIGIT_W, 2, substitution digit width (1..4)
- Derived: N = WORD_W/DIGIT_W digits; T = 2**DIGIT_W table entries; KEY_W = T*DIGIT_W
- Clk  input  1  single clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  request; accepted only in IDLE or DONE
- Mode  input  1  0 = forward substitution, 1 = inverse substitution; latched at accept
- In  input  WORD_W  data word; latched at accept
- Key  input  KEY_W  table; entry k = Key[k*DIGIT_W +: DIGIT_W] is the substitute for value k; latched at accept
- Out  output  WORD_W  result word; held until the next completion
- Busy  output  1  high while the FSM is in RUN
- Done  output  1  one-cycle pulse; Out and KeyErr are valid while it is high
- KeyErr  output  1  latched key is not a permutation; updated at completion

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, Start=1 → RUN:
  - latch In, Key and Mode
  - digit counter := 0
  - compute the permutation check on the latched key
- IDLE, Start=0 → IDLE. DONE, Start=0 → IDLE.
- RUN, each edge:
  - digit j = work[j*DIGIT_W +: DIGIT_W], processed LSB digit first (j = 0..N-1)
  - substituted result written to res[j*DIGIT_W +: DIGIT_W]
  - counter increments
  - on j = N-1 → DONE, and Out := the completed result
- Forward: sub(v) = Key entry v.
- Inverse: sub(v) = lowest index k whose entry equals v. If no entry equals v, sub(v) = 0.
- Permutation check: KeyErr = 1 if any two entries are equal. KeyErr is computed from the latched key and presented with Done in both modes.
- Start during RUN is ignored (not queued). In, Key and Mode changes during RUN have no effect.
- Only Out, Busy, Done and KeyErr are visible. Internal working registers are don't-care outside RUN.

## Timing
- Reset values: state IDLE, Out = 0, Busy = 0, Done = 0, KeyErr = 0, counter = 0.
- Accept edge t0: Busy = 1 from t0 until the edge t0+N.
- Digit j is resolved at edge t0+1+j.
- After edge t0+N: state DONE, Busy = 0, Done = 1 for exactly one cycle, Out and KeyErr updated.
- Accept-to-Done latency is N cycles. N=1 is legal: DONE is reached one edge after accept.
- Back-to-back: Start held high in DONE is accepted at the DONE edge. Throughput is one word per N+1 cycles. Done still pulses one cycle per word.
- Rst asserted at any time: immediate return to reset values, and the in-flight word is discarded with no Done.
- Release of Rst is assumed synchronous to Clk. The first accept can occur at the first edge after release.
- Out does not glitch during RUN; it changes only on entry to DONE or on reset.

## Test plan
- Default parameters, Key = 8'h1E (0→2, 1→3, 2→1, 3→0), Mode = 0, In = 8'h1B, Start pulse:
  - Busy high for 4 cycles
  - Done at accept + 4 with Out = 8'hB4, KeyErr = 0
- Same key, Mode = 1, In = 8'hB4 → Out = 8'h1B at accept + 4, KeyErr = 0.
- Key = 8'h00:
  - Mode = 0, In = 8'hFF → Out = 8'h00, KeyErr = 1
  - Mode = 1, In = 8'h55 → Out = 8'h00, KeyErr = 1
- Start re-pulsed during RUN, and In/Key changed mid-run → ignored. Single Done with the originally latched result. Start held high continuously → Done pulses every 5 cycles.
- Rst asserted at accept + 2:
  - Busy, Done and Out go to 0 immediately, with no Done pulse
  - a new request after release completes normally with the correct Out
- WORD_W = 16, DIGIT_W = 4, Key = 64'hFEDCBA9876543210 (identity), In = 16'hA5C3:
  - Out = 16'hA5C3 at accept + 4 in both modes, KeyErr = 0
  - with Key entry 0 changed to 1 → KeyErr = 1
